// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: Moore sequencer for the accumulator processor; decodes IR[4:0]
// and drives every datapath select/enable per state, with halt and sticky illegal flags.
module multicycle_control_unit (
  input  logic       CLK,
  input  logic       Reset,
  input  logic [4:0] Opcode,
  input  logic       Zero,
  output logic       PCWrite,
  output logic       IRWrite,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic       SPWrite,
  output logic [1:0] IorD,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUOp,
  output logic [1:0] PCSrc,
  output logic [1:0] OperandSrc,
  output logic [2:0] ReturnSrc,
  output logic [1:0] RegFileSrc,
  output logic       InstrDone,
  output logic       Halted,
  output logic       Illegal,
  output logic [3:0] StateOut
);
  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    EXEC_R   = 4'd2,
    EXEC_I   = 4'd3,
    WB_ALU   = 4'd4,
    WB_IMM   = 4'd5,
    WB_MOVE  = 4'd6,
    MEM_ADDR = 4'd7,
    MEM_RD   = 4'd8,
    WB_MEM   = 4'd9,
    MEM_WR   = 4'd10,
    BRANCH   = 4'd11,
    JUMP     = 4'd12,
    SP_DEC   = 4'd13,
    SP_INC   = 4'd14,
    HALT     = 4'd15
  } state_t;
  localparam logic [4:0] OP_LW  = 5'h06;
  localparam logic [4:0] OP_POP = 5'h0C;
  localparam logic [4:0] OP_HLT = 5'h1F;
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  state_t state, next;
  logic [4:0] op_q;
  logic illegal_q;
  logic legal;
  assign legal = (Opcode <= OP_POP) || (Opcode == OP_HLT);
  assign StateOut = state;
  assign Illegal = illegal_q;
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state     <= FETCH;
      op_q      <= '0;
      illegal_q <= 1'b0;
    end else begin
      state <= next;
      if (state == DECODE) begin
        op_q <= Opcode;
        if (!legal) illegal_q <= 1'b1;
      end
    end
  end
  always_comb begin
    next = state;
    case (state)
      FETCH:    next = DECODE;
      DECODE: begin
        case (Opcode)
          5'h00, 5'h01, 5'h02, 5'h03: next = EXEC_R;
          5'h04:   next = EXEC_I;
          5'h05:   next = WB_IMM;
          5'h06, 5'h07: next = MEM_ADDR;
          5'h08:   next = WB_MOVE;
          5'h09:   next = BRANCH;
          5'h0A:   next = JUMP;
          5'h0B:   next = SP_DEC;
          5'h0C:   next = MEM_RD;
          default: next = HALT;
        endcase
      end
      EXEC_R, EXEC_I: next = WB_ALU;
      MEM_ADDR: next = (op_q == OP_LW) ? MEM_RD : MEM_WR;
      MEM_RD:   next = WB_MEM;
      WB_MEM:   next = (op_q == OP_POP) ? SP_INC : FETCH;
      SP_DEC:   next = MEM_WR;
      HALT:     next = HALT;
      default:  next = FETCH;
    endcase
  end
  // Outputs are forced low while Reset is high, since the state register alone reads FETCH.
  always_comb begin
    PCWrite    = 1'b0;
    IRWrite    = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    RegWrite   = 1'b0;
    SPWrite    = 1'b0;
    IorD       = 2'b00;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ALUOp      = ALU_ADD;
    PCSrc      = 2'b00;
    OperandSrc = 2'b00;
    ReturnSrc  = 3'b000;
    RegFileSrc = 2'b00;
    InstrDone  = 1'b0;
    Halted     = 1'b0;
    if (!Reset) begin
      case (state)
        FETCH: begin
          MemRead = 1'b1;
          IRWrite = 1'b1;
          ALUSrcB = 2'b01;
          PCWrite = 1'b1;
        end
        DECODE:   ALUSrcB = 2'b10;
        EXEC_R: begin
          ALUSrcA = 2'b01;
          ALUOp   = op_q[2:0];
        end
        EXEC_I, MEM_ADDR: begin
          ALUSrcA = 2'b01;
          ALUSrcB = 2'b10;
        end
        WB_ALU: begin
          RegWrite   = 1'b1;
          RegFileSrc = 2'b10;
          InstrDone  = 1'b1;
        end
        WB_IMM: begin
          RegWrite   = 1'b1;
          RegFileSrc = 2'b11;
          InstrDone  = 1'b1;
        end
        WB_MOVE: begin
          RegWrite   = 1'b1;
          RegFileSrc = 2'b01;
          ReturnSrc  = 3'b001;
          InstrDone  = 1'b1;
        end
        MEM_RD: begin
          MemRead = 1'b1;
          IorD    = (op_q == OP_POP) ? 2'b10 : 2'b01;
        end
        WB_MEM: begin
          RegWrite  = 1'b1;
          InstrDone = (op_q != OP_POP);
        end
        MEM_WR: begin
          MemWrite  = 1'b1;
          IorD      = 2'b01;
          InstrDone = 1'b1;
        end
        SP_DEC: begin
          ALUSrcA = 2'b10;
          ALUSrcB = 2'b01;
          ALUOp   = ALU_SUB;
          SPWrite = 1'b1;
        end
        SP_INC: begin
          ALUSrcA   = 2'b10;
          ALUSrcB   = 2'b01;
          SPWrite   = 1'b1;
          InstrDone = 1'b1;
        end
        BRANCH: begin
          ALUSrcA   = 2'b01;
          ALUOp     = ALU_SUB;
          PCSrc     = 2'b01;
          PCWrite   = Zero;
          InstrDone = 1'b1;
        end
        JUMP: begin
          PCSrc     = 2'b10;
          PCWrite   = 1'b1;
          InstrDone = 1'b1;
        end
        HALT:     Halted = 1'b1;
        default:  Halted = 1'b0;
      endcase
    end
  end
endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb_multicycle_control_unit: random instruction stream checked against a per-instruction
// trace model (state sequence plus expected control word each cycle).
module tb_multicycle_control_unit;
  logic       CLK;
  logic       Reset;
  logic [4:0] Opcode;
  logic       Zero;
  logic       PCWrite, IRWrite, MemRead, MemWrite, RegWrite, SPWrite;
  logic [1:0] IorD, ALUSrcA, ALUSrcB, PCSrc, OperandSrc, RegFileSrc;
  logic [2:0] ALUOp, ReturnSrc;
  logic       InstrDone, Halted, Illegal;
  logic [3:0] StateOut;

  typedef struct packed {
    logic       pcw, irw, mr, mw, rw, spw;
    logic [1:0] iord, srca, srcb;
    logic [2:0] aluop;
    logic [1:0] pcsrc, opsrc;
    logic [2:0] retsrc;
    logic [1:0] rfsrc;
    logic       done, halted;
  } out_t;
  typedef struct {
    int   st;
    out_t o;
  } step_t;

  out_t  got;
  step_t q[$];
  int    total = 0;
  int    bad = 0;

  assign got = {PCWrite, IRWrite, MemRead, MemWrite, RegWrite, SPWrite, IorD, ALUSrcA, ALUSrcB,
                ALUOp, PCSrc, OperandSrc, ReturnSrc, RegFileSrc, InstrDone, Halted};

  multicycle_control_unit dut (
    .CLK(CLK), .Reset(Reset), .Opcode(Opcode), .Zero(Zero),
    .PCWrite(PCWrite), .IRWrite(IRWrite), .MemRead(MemRead), .MemWrite(MemWrite),
    .RegWrite(RegWrite), .SPWrite(SPWrite), .IorD(IorD), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSrc(PCSrc), .OperandSrc(OperandSrc),
    .ReturnSrc(ReturnSrc), .RegFileSrc(RegFileSrc), .InstrDone(InstrDone),
    .Halted(Halted), .Illegal(Illegal), .StateOut(StateOut)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] g, input logic [31:0] e);
    total++;
    if (g !== e) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, g, e);
    end
  endtask

  function automatic void push(input int st, input out_t o);
    step_t t;
    t.st = st;
    t.o  = o;
    q.push_back(t);
  endfunction

  function automatic int cpi(input logic [4:0] op);
    if (op == 5'h05 || op == 5'h08 || op == 5'h09 || op == 5'h0A) return 3;
    if (op == 5'h06 || op == 5'h0C) return 5;
    return 4;
  endfunction

  // Trace of one legal instruction; InstrDone belongs to whichever step comes last.
  function automatic void build(input logic [4:0] op, input logic z);
    out_t  o;
    step_t t;
    q.delete();
    o = '0; o.mr = 1; o.irw = 1; o.srcb = 2'd1; o.pcw = 1; push(0, o);
    o = '0; o.srcb = 2'd2; push(1, o);
    case (op)
      5'h00, 5'h01, 5'h02, 5'h03, 5'h04: begin
        o = '0; o.srca = 2'd1;
        if (op == 5'h04) begin o.srcb = 2'd2; push(3, o); end
        else begin o.aluop = op[2:0]; push(2, o); end
        o = '0; o.rw = 1; o.rfsrc = 2'd2; push(4, o);
      end
      5'h05: begin o = '0; o.rw = 1; o.rfsrc = 2'd3; push(5, o); end
      5'h06: begin
        o = '0; o.srca = 2'd1; o.srcb = 2'd2; push(7, o);
        o = '0; o.mr = 1; o.iord = 2'd1; push(8, o);
        o = '0; o.rw = 1; push(9, o);
      end
      5'h07: begin
        o = '0; o.srca = 2'd1; o.srcb = 2'd2; push(7, o);
        o = '0; o.mw = 1; o.iord = 2'd1; push(10, o);
      end
      5'h08: begin o = '0; o.rw = 1; o.rfsrc = 2'd1; o.retsrc = 3'd1; push(6, o); end
      5'h09: begin o = '0; o.srca = 2'd1; o.aluop = 3'd1; o.pcsrc = 2'd1; o.pcw = z; push(11, o); end
      5'h0A: begin o = '0; o.pcsrc = 2'd2; o.pcw = 1; push(12, o); end
      5'h0B: begin
        o = '0; o.srca = 2'd2; o.srcb = 2'd1; o.aluop = 3'd1; o.spw = 1; push(13, o);
        o = '0; o.mw = 1; o.iord = 2'd1; push(10, o);
      end
      default: begin
        o = '0; o.mr = 1; o.iord = 2'd2; push(8, o);
        o = '0; o.rw = 1; push(9, o);
        o = '0; o.srca = 2'd2; o.srcb = 2'd1; o.spw = 1; push(14, o);
      end
    endcase
    t = q.pop_back();
    t.o.done = 1'b1;
    q.push_back(t);
  endfunction

  // Entered just after a negedge with the DUT in FETCH; leaves it the same way.
  task automatic run_instr(input logic [4:0] op, input logic z);
    int done_at;
    done_at = -1;
    build(op, z);
    Opcode = op;
    Zero   = z;
    for (int i = 0; i < q.size(); i++) begin
      if (i >= 2) Opcode = 5'($urandom);
      #1;
      check($sformatf("state op%0h c%0d", op, i), 32'(StateOut), 32'(q[i].st));
      check($sformatf("outs op%0h c%0d", op, i), 32'(got), 32'(q[i].o));
      if (InstrDone) done_at = i + 1;
      @(negedge CLK);
    end
    #1;
    check($sformatf("cpi op%0h", op), 32'(done_at), 32'(cpi(op)));
    check($sformatf("refetch op%0h", op), 32'(StateOut), 32'd0);
    check($sformatf("illegal op%0h", op), 32'(Illegal), 32'd0);
  endtask

  task automatic run_halt(input logic [4:0] op, input logic ill);
    out_t h;
    h = '0;
    h.halted = 1'b1;
    Opcode = op;
    #1;
    check("halt fetch", 32'(StateOut), 32'd0);
    @(negedge CLK);
    #1;
    check("halt decode", 32'(StateOut), 32'd1);
    @(negedge CLK);
    Opcode = 5'h00;
    repeat (10) begin
      #1;
      check("halt state", 32'(StateOut), 32'd15);
      check("halt outs", 32'(got), 32'(h));
      check("halt illegal", 32'(Illegal), 32'(ill));
      @(negedge CLK);
    end
    #2;
    Reset = 1'b1;
    #1;
    check("async rst state", 32'(StateOut), 32'd0);
    check("async rst outs", 32'(got), 32'd0);
    check("async rst illegal", 32'(Illegal), 32'd0);
    @(negedge CLK);
    Reset = 1'b0;
  endtask

  initial begin
    Reset  = 1'b1;
    Opcode = 5'h00;
    Zero   = 1'b0;
    repeat (3) begin
      @(negedge CLK);
      #1;
      check("rst state", 32'(StateOut), 32'd0);
      check("rst outs", 32'(got), 32'd0);
      check("rst illegal", 32'(Illegal), 32'd0);
    end
    Reset = 1'b0;
    run_instr(5'h00, 1'b0);
    run_instr(5'h06, 1'b0);
    run_instr(5'h07, 1'b0);
    run_instr(5'h0B, 1'b0);
    run_instr(5'h0C, 1'b0);
    run_instr(5'h09, 1'b1);
    run_instr(5'h09, 1'b0);
    for (int op = 1; op <= 5; op++) run_instr(5'(op), 1'b0);
    run_instr(5'h08, 1'b1);
    run_instr(5'h0A, 1'b0);
    // Reset during MEM_ADDR of a lw must abandon it with no further enables.
    Opcode = 5'h06;
    @(negedge CLK);
    @(negedge CLK);
    #1;
    Reset = 1'b1;
    #1;
    check("mid rst state", 32'(StateOut), 32'd0);
    check("mid rst outs", 32'(got), 32'd0);
    @(negedge CLK);
    Reset = 1'b0;
    run_instr(5'h04, 1'b0);
    for (int n = 0; n < 150; n++) run_instr(5'($urandom_range(0, 12)), 1'($urandom));
    run_halt(5'h15, 1'b1);
    run_instr(5'h06, 1'b0);
    run_halt(5'h1F, 1'b0);
    run_instr(5'h0C, 1'b1);
    run_halt(5'h0D, 1'b1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/multicycle_control_unit.md
# multicycle_control_unit

Moore-style multicycle sequencer for the accumulator processor. It decodes the 5-bit opcode in IR[4:0] and steps through fetch, decode, execute, memory and writeback states. Each cycle it drives every select and write-enable of the register-file/immediate-generator/SP datapath, plus PC, IR, ALU and memory. It also flags halt and illegal-opcode conditions.

## Interface
- No parameters; widths are fixed by the datapath.
- CLK  in  1  system clock; all state changes on rising edge
- Reset  in  1  asynchronous, active-high
- Opcode  in  5  IR[4:0], valid from DECODE onward (IR is written in FETCH)
- Zero  in  1  ALU zero flag, sampled in BRANCH
- PCWrite, IRWrite, MemRead, MemWrite, RegWrite, SPWrite  out  1 each  write/read enables
- IorD  out  2  memory address: 00 PC, 01 ALUOut, 10 SP
- ALUSrcA  out  2  00 PC, 01 RegA, 10 SP
- ALUSrcB  out  2  00 RegB, 01 constant 2, 10 ImmGen
- ALUOp  out  3  000 add, 001 sub, 010 and, 011 or
- PCSrc  out  2  00 ALU result, 01 ALUOut, 10 ImmGen
- OperandSrc  out  2  R1 select, same encoding as the regfile block
- ReturnSrc  out  3  Rd select, same encoding as the regfile block
- RegFileSrc  out  2  write data: 00 MDR, 01 RegB, 10 ALUOut, 11 ImmGen
- InstrDone  out  1  one-cycle pulse in the last state of each instruction
- Halted  out  1  high while in HALT
- Illegal  out  1  sticky; set on an undefined opcode
- StateOut  out  4  current state encoding, for debug and verification

## Operation
- States and encodings: FETCH 0, DECODE 1, EXEC_R 2, EXEC_I 3, WB_ALU 4, WB_IMM 5, WB_MOVE 6, MEM_ADDR 7, MEM_RD 8, WB_MEM 9, MEM_WR 10, BRANCH 11, JUMP 12, SP_DEC 13, SP_INC 14, HALT 15.
- Any output not listed for a state is 0.
- FETCH: MemRead, IorD=00, IRWrite, ALUSrcA=00, ALUSrcB=01, ALUOp=add, PCSrc=00, PCWrite (PC<=PC+2). Next state DECODE.
- DECODE: OperandSrc=00, ALUSrcA=00, ALUSrcB=10, add (ALUOut<=branch target). Next state by opcode:
  - 0x00-0x03 add/sub/and/or -> EXEC_R
  - 0x04 addi -> EXEC_I
  - 0x05 li -> WB_IMM
  - 0x06 lw, 0x07 sw -> MEM_ADDR
  - 0x08 mv -> WB_MOVE
  - 0x09 beq -> BRANCH
  - 0x0A j -> JUMP
  - 0x0B push -> SP_DEC
  - 0x0C pop -> MEM_RD with IorD=10
  - 0x1F halt -> HALT
  - any other opcode -> HALT and set Illegal
- EXEC_R: ALUSrcA=01, ALUSrcB=00, ALUOp=Opcode[2:0]. Next WB_ALU.
- EXEC_I: ALUSrcA=01, ALUSrcB=10, add. Next WB_ALU.
- WB_ALU: RegWrite, RegFileSrc=10, ReturnSrc=000, InstrDone. Next FETCH.
- WB_IMM: RegWrite, RegFileSrc=11, ReturnSrc=000, InstrDone.
- WB_MOVE: RegWrite, RegFileSrc=01, ReturnSrc=001, InstrDone.
- MEM_ADDR: ALUSrcA=01, ALUSrcB=10, add. Next MEM_RD (lw) or MEM_WR (sw).
- MEM_RD: MemRead. IorD=01 for lw, 10 for pop. Next WB_MEM.
- WB_MEM: RegWrite, RegFileSrc=00, ReturnSrc=000. For lw: InstrDone, next FETCH. For pop: next SP_INC.
- MEM_WR: MemWrite, IorD=01, InstrDone. Write data is RegA; the datapath owns that path.
- SP_DEC: ALUSrcA=10, ALUSrcB=01, sub, SPWrite (SP and ALUOut <= SP-2). Next MEM_WR.
- SP_INC: ALUSrcA=10, ALUSrcB=01, add, SPWrite, InstrDone.
- BRANCH: ALUSrcA=01, ALUSrcB=00, sub, PCSrc=01, PCWrite=Zero, InstrDone.
- JUMP: PCSrc=10, PCWrite, InstrDone.
- HALT: Halted=1. All enables are 0. The state holds until Reset.
- The opcode is registered in DECODE and used by later states. Changes to the Opcode input after DECODE have no effect.

## Timing
- Reset asserted: state goes to FETCH immediately (asynchronous). While Reset is high, every enable, InstrDone and Halted is 0. Illegal clears to 0.
- First FETCH cycle is the first rising edge after Reset deasserts.
- Reset mid-instruction abandons that instruction. No enable pulses after the reset edge.
- Cycles per instruction:
  - li, mv, beq, j: 3
  - ALU ops, addi, sw, push: 4
  - lw, pop: 5
- InstrDone pulses exactly once per instruction and never in HALT.
- beq with Zero=0: PC keeps the PC+2 value written in FETCH.

## Test plan
- Reset held for 3 cycles, then released: StateOut=0, all enables 0 while Reset is high. First edge after release shows IRWrite=PCWrite=MemRead=1.
- add (0x00): states 0,1,2,4. In state 4: RegWrite=1, RegFileSrc=10, ALUOp=000 seen in state 2. InstrDone on cycle 4.
- lw (0x06) then sw (0x07): state sequences 0,1,7,8,9 and 0,1,7,10. MemWrite is high for exactly 1 cycle.
- push (0x0B) then pop (0x0C): push issues SPWrite with ALUOp=sub, then MemWrite with IorD=01. Pop runs MEM_RD with IorD=10, then WB_MEM, then SP_INC with SPWrite and add. 4 and 5 cycles.
- beq (0x09) with Zero=1 and with Zero=0: PCWrite is 1 and 0 respectively in BRANCH, PCSrc=01 in both.
- Opcode 0x15: goes to HALT, Illegal=1, Halted=1, no enables for 10 cycles. Async Reset mid-HALT clears Illegal and returns StateOut to 0 before the next edge.
